// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared row geometry, FSM encoding and sample select helper
package jpeg_pkg;

  localparam int SAMP_W     = 9;
  localparam int SAMP_PER_W = 16;
  localparam int ROW_W      = SAMP_W * SAMP_PER_W;
  localparam int IDX_W      = $clog2(SAMP_PER_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [SAMP_W-1:0] sample_sel(input logic [ROW_W-1:0] row,
                                                   input logic [IDX_W-1:0] k);
    return row[SAMP_W*k +: SAMP_W];
  endfunction

endpackage

// File: rtl/jpeg_word_buf.sv
// rtl/jpeg_word_buf.sv - two-slot row buffer (CUR/NXT) with sample counter and output mux
module jpeg_word_buf
  import jpeg_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ROW_W-1:0]  i_wr_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [SAMP_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_nxt_full,
  output logic              o_drain
);

  logic [ROW_W-1:0] r_cur;
  logic [ROW_W-1:0] r_nxt;
  logic             r_cur_full;
  logic             r_nxt_full;
  logic [IDX_W-1:0] r_k;

  logic w_hs;
  logic w_drain;

  assign w_hs    = r_cur_full & i_ready;
  assign w_drain = w_hs & (r_k == IDX_W'(SAMP_PER_W - 1));

  assign o_valid    = r_cur_full;
  assign o_data     = sample_sel(r_cur, r_k);
  assign o_index    = r_k;
  assign o_nxt_full = r_nxt_full;
  assign o_drain    = w_drain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur      <= '0;
      r_nxt      <= '0;
      r_cur_full <= 1'b0;
      r_nxt_full <= 1'b0;
      r_k        <= '0;
    end else begin
      if (w_hs) begin
        r_k <= r_k + IDX_W'(1);
      end
      // On the last sample CUR is refilled in the same cycle so the stream has no bubble.
      if (w_drain) begin
        if (r_nxt_full) begin
          r_cur      <= r_nxt;
          r_nxt_full <= i_wr_en;
          if (i_wr_en) begin
            r_nxt <= i_wr_data;
          end
        end else begin
          r_cur_full <= i_wr_en;
          if (i_wr_en) begin
            r_cur <= i_wr_data;
          end
        end
      end else if (i_wr_en) begin
        if (!r_cur_full) begin
          r_cur      <= i_wr_data;
          r_cur_full <= 1'b1;
        end else begin
          r_nxt      <= i_wr_data;
          r_nxt_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jpeg_row_unpacker.sv
// rtl/jpeg_row_unpacker.sv - streams packed 16x9-bit line RAM rows out one sample per clock
module jpeg_row_unpacker
  import jpeg_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_num_words,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_re,
  input  logic [ROW_W-1:0]  i_ram_dout,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [SAMP_W-1:0] o_m_data,
  output logic [IDX_W-1:0]  o_m_index,
  output logic              o_m_last
);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_ram_re;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_req_left;
  logic [ADDR_W-1:0] r_words_left;
  logic              r_re_d;

  logic              w_valid;
  logic [IDX_W-1:0]  w_index;
  logic              w_nxt_full;
  logic              w_drain;
  logic              w_issue;
  logic              w_last;

  jpeg_word_buf u_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (r_re_d),
    .i_wr_data  (i_ram_dout),
    .i_ready    (i_m_ready),
    .o_valid    (w_valid),
    .o_data     (o_m_data),
    .o_index    (w_index),
    .o_nxt_full (w_nxt_full),
    .o_drain    (w_drain)
  );

  // At most one word in flight and only into an empty NXT: never more than two words ahead.
  assign w_issue = (r_state == ST_RUN) && (r_req_left != '0) && !w_nxt_full
                   && !r_ram_re && !r_re_d;
  assign w_last  = (r_words_left == ADDR_W'(1)) && (w_index == IDX_W'(SAMP_PER_W - 1))
                   && w_valid;

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_ram_re   = r_ram_re;
  assign o_ram_addr = r_ram_addr;
  assign o_m_valid  = w_valid;
  assign o_m_index  = w_index;
  assign o_m_last   = w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ram_re     <= 1'b0;
      r_ram_addr   <= '0;
      r_rd_ptr     <= '0;
      r_req_left   <= '0;
      r_words_left <= '0;
      r_re_d       <= 1'b0;
    end else begin
      r_re_d   <= r_ram_re;
      r_ram_re <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_num_words == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              // First read goes out on the start edge itself.
              r_state      <= ST_RUN;
              r_ram_re     <= 1'b1;
              r_ram_addr   <= i_base_addr;
              r_rd_ptr     <= i_base_addr + ADDR_W'(1);
              r_req_left   <= i_num_words - ADDR_W'(1);
              r_words_left <= i_num_words;
            end
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_ram_re   <= 1'b1;
            r_ram_addr <= r_rd_ptr;
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            r_req_left <= r_req_left - ADDR_W'(1);
          end
          if (w_drain) begin
            r_words_left <= r_words_left - ADDR_W'(1);
          end
          if (w_last && i_m_ready) begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
